// File: rtl/systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_tile_ctrl
//   Tile sequencer for an ArrSize x ArrSize output-stationary MAC array.
//   Each accepted start runs one tile through these steps:
//     1. Clear the PE accumulators.
//     2. Stream k_len operand beats.
//     3. Flush the operand skew pipeline.
//     4. Drain the results one row per valid/ready handshake.
//     5. Pulse done.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   start     : tile request, sampled only in IDLE
//   k_len     : operand beats for the tile, latched on an accepted start
//   busy      : high in every state except IDLE
//   done      : one-cycle completion pulse
//   pe_clear  : accumulator clear to all PEs
//   feed_en   : operand beat issued this cycle (low => array edge inputs zero)
//   rd_addr   : operand buffer read address (beat index), 0 outside FEED
//   row_sel   : result row presented on the drain bus
//   out_valid : result row valid
//   out_ready : result consumer ready
//   out_last  : final row marker (row_sel == ArrSize-1)
//
// All outputs are decoded from registered state only. No combinational path
// runs from any input to any output.
// -----------------------------------------------------------------------------
module systolic_tile_ctrl #(
  parameter int ArrSize   = 4,
  parameter int KWidth    = 16,
  parameter int AddrWidth = 16,
  parameter int RdLatency = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KWidth-1:0]          k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       pe_clear,
  output logic                       feed_en,
  output logic [AddrWidth-1:0]       rd_addr,
  output logic [$clog2(ArrSize)-1:0] row_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  // The flush window covers the read latency plus the worst-case skew and
  // propagation delay to PE(ArrSize-1, ArrSize-1).
  localparam int FlushCycles = RdLatency + 2 * ArrSize - 1;
  localparam int FlushW      = $clog2(FlushCycles + 1);
  localparam int RowW        = $clog2(ArrSize);

  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushCycles - 1);
  localparam logic [RowW-1:0]   RowLast   = RowW'(ArrSize - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [KWidth-1:0] k_len_q;
  logic [KWidth-1:0] beat_cnt;
  logic [FlushW-1:0] flush_cnt;
  logic [RowW-1:0]   row_cnt;

  // NOTE: state is written only with non-blocking assignments inside a single
  // always_ff block. This keeps every register update race-free against the
  // other registers sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              k_len_q <= k_len;
              state   <= S_CLEAR;
            end else begin
              // An empty tile skips the array entirely and only reports completion.
              state <= S_DONE;
            end
          end
        end

        S_CLEAR: begin
          beat_cnt <= '0;
          state    <= S_FEED;
        end

        S_FEED: begin
          // Compare against k_len_q-1 rather than counting to k_len_q.
          // This way the beat counter never wraps, even at the maximum k_len.
          if (beat_cnt == k_len_q - KWidth'(1)) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else begin
            beat_cnt <= beat_cnt + KWidth'(1);
          end
        end

        S_FLUSH: begin
          if (flush_cnt == FlushLast) begin
            flush_cnt <= '0;
            row_cnt   <= '0;
            state     <= S_DRAIN;
          end else begin
            flush_cnt <= flush_cnt + FlushW'(1);
          end
        end

        S_DRAIN: begin
          // row_cnt advances only on a completed handshake. Under backpressure
          // it holds, which keeps row_sel stable while out_valid stays high.
          if (out_ready) begin
            if (row_cnt == RowLast) begin
              row_cnt <= '0;
              state   <= S_DONE;
            end else begin
              row_cnt <= row_cnt + RowW'(1);
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state. Reset forces them to zero
  // in the same cycle because it drives the state to IDLE asynchronously.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign pe_clear  = (state == S_CLEAR);
  assign feed_en   = (state == S_FEED);
  assign rd_addr   = feed_en ? AddrWidth'(beat_cnt) : '0;
  assign out_valid = (state == S_DRAIN);
  assign row_sel   = out_valid ? row_cnt : '0;
  assign out_last  = out_valid && (row_cnt == RowLast);

endmodule
